usb_ep_arbiter: RTL and testbench
=================================

# usb_ep_arbiter

Round-robin arbiter that shares one USB packet-buffer port between several endpoint requesters: the control endpoint, the CDC data endpoints and the interrupt endpoint. Each requester raises `req` and waits for its one-hot `grant`; the requester keeps ownership for as long as it holds `req`. The block sits between the endpoint modules and the protocol engine's IN/OUT buffer interfaces and drives the buffer-port select mux from `grant_id`. A hold watchdog revokes ownership from a requester that keeps the port too long.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `MAX_HOLD`, default 1024: maximum consecutive cycles one grant may stay asserted; 0 disables the watchdog.
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: reset, synchronous, active-high.
- `req` input, `NUM_REQ` bits: per-requester request, level-sensitive.
- `grant` output, `NUM_REQ` bits: one-hot grant, registered.
- `grant_valid` output, 1 bit: high when any `grant` bit is high.
- `grant_id` output, `max(1,$clog2(NUM_REQ))` bits: index of the current or last granted requester, registered.
- `hold_timeout` output, 1 bit: one-cycle pulse when the watchdog revokes a grant.
- `timeout_id` output, same width as `grant_id`: index of the revoked requester; valid while `hold_timeout` is high, otherwise it holds its last value.

## Operation
- The block has three states: IDLE, GRANT, RELEASE.
- IDLE:
  - If any `req` bit is high after masking, select the winner, set `grant` to that winner, load `grant_id`, clear the hold counter and go to GRANT.
  - Otherwise stay in IDLE with `grant` equal to 0.
- Winner selection: search upward from pointer `rr_ptr`, wrapping past `NUM_REQ-1` to 0. The first requester with an unmasked `req` wins.
- GRANT:
  - If `req[grant_id]` is 0, clear `grant`, set `rr_ptr` to `grant_id+1` (modulo `NUM_REQ`) and go to RELEASE.
  - Else, if `MAX_HOLD` is not 0 and the hold counter equals `MAX_HOLD-1`:
    - clear `grant` and pulse `hold_timeout`;
    - set `timeout_id` to `grant_id`;
    - set `rr_ptr` to `grant_id+1`;
    - set `revoke_mask[grant_id]`;
    - go to RELEASE.
  - Else increment the hold counter and stay in GRANT.
- RELEASE: lasts exactly one cycle with `grant` equal to 0, then goes to IDLE. This cycle gives the buffer-port mux a clean turnaround.
- `revoke_mask`:
  - A set bit excludes that requester from arbitration.
  - Bit i clears in any cycle where `req[i]` is 0.
  - A revoked requester must drop `req` and re-raise it before it can win again.
- Hold counter width is `$clog2(MAX_HOLD+1)`. It saturates and never wraps.
- `grant` has at most one bit high in every cycle. `grant_valid` is the OR of `grant`.
- Reset values:
  - state IDLE; `grant` 0; `grant_valid` 0;
  - `grant_id` 0; `hold_timeout` 0; `timeout_id` 0;
  - `rr_ptr` 0; `revoke_mask` 0; hold counter 0.
- Reset asserted mid-grant: `grant` drops in the next cycle. No `hold_timeout` pulse is generated.
- Out-of-range `rr_ptr` cannot occur; the increment is modulo `NUM_REQ`.

## Timing
- `req` rises at cycle N in IDLE: `grant` is high at N+1. Latency is one cycle.
- The granted `req` falls at cycle M: `grant` is low at M+1 (RELEASE). The earliest next grant is at M+2.
- Back-to-back arbitration: the minimum gap between two grants is one idle cycle.
- The watchdog allows `grant` to stay high for at most `MAX_HOLD` consecutive cycles. In the following cycle `grant` is 0 and `hold_timeout` is 1.
- Simultaneous requests are resolved in the same cycle by `rr_ptr` order. Requests arriving during GRANT or RELEASE wait and are evaluated in IDLE.
- A non-granted `req` that rises and falls while another requester holds the grant is lost; no latching is done. Requesters must hold `req` until granted.
- If the granted `req` falls in the same cycle the hold counter reaches `MAX_HOLD-1`, the release path wins: no timeout pulse and no mask bit is set.

## Test plan
- Single requester, `NUM_REQ`=4: raise `req[2]` at cycle 10 and drop it at cycle 20 -> `grant`=0100 during cycles 11..20, 0 at cycle 21, `grant_id`=2.
- All four `req` held continuously from reset, each dropped 3 cycles after its grant -> grant order 0,1,2,3,0, each grant separated by one zero cycle.
- Round-robin fairness: `req[1]` and `req[3]` both held, each released and re-raised immediately after every grant -> grants alternate 1,3,1,3; `req[1]` never wins twice in a row.
- Watchdog with `MAX_HOLD`=8: `req[0]` held forever and `req[1]` held -> `grant[0]` high for exactly 8 cycles; then `hold_timeout`=1 and `timeout_id`=0; then `grant[1]`; `req[0]` is not re-granted until it toggles low.
- Release/timeout tie with `MAX_HOLD`=8: drop `req[0]` in the 8th grant cycle -> `hold_timeout` stays 0 and `revoke_mask` stays 0.
- Reset during grant: assert `reset` at the 5th cycle of `grant[3]` -> all outputs 0 next cycle; a subsequent all-`req` pattern is granted to requester 0 first.

Source files
------------

// File: rtl/usb_ep_arbiter.sv
// Round-robin arbiter sharing one USB packet-buffer port between endpoint requesters.
// Ownership lasts while req is held; a hold watchdog revokes grants that run too long.
module usb_ep_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 1024,
    localparam int IDW     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDW-1:0]     grant_id,
    output logic               hold_timeout,
    output logic [IDW-1:0]     timeout_id
);

    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;
    localparam logic [CW-1:0] HOLD_SAT  = '1;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t               state_reg;
    logic [IDW-1:0]       rr_ptr_reg;
    logic [NUM_REQ-1:0]   revoke_mask_reg;
    logic [CW-1:0]        hold_cnt_reg;

    logic [NUM_REQ-1:0]   masked_req;
    logic [IDW-1:0]       cand_id [NUM_REQ];
    logic                 win_found;
    logic [IDW-1:0]       win_id;
    logic [IDW-1:0]       ptr_next;

    assign masked_req  = req & ~revoke_mask_reg;
    assign grant_valid = |grant;
    assign ptr_next    = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);

    // cand_id[gi] is the requester examined gi positions after rr_ptr, wrapping modulo NUM_REQ
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDW:0] sum;
            assign sum = {1'b0, rr_ptr_reg} + (IDW+1)'(gi);
            assign cand_id[gi] = (sum >= (IDW+1)'(NUM_REQ)) ? IDW'(sum - (IDW+1)'(NUM_REQ))
                                                            : sum[IDW-1:0];
        end
    endgenerate

    // Scan from the far end so the candidate closest to rr_ptr is the last writer
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (masked_req[cand_id[k]]) begin
                win_found = 1'b1;
                win_id    = cand_id[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            grant           <= '0;
            grant_id        <= '0;
            hold_timeout    <= 1'b0;
            timeout_id      <= '0;
            rr_ptr_reg      <= '0;
            revoke_mask_reg <= '0;
            hold_cnt_reg    <= '0;
        end else begin
            hold_timeout    <= 1'b0;
            revoke_mask_reg <= revoke_mask_reg & req;
            case (state_reg)
                // RELEASE holds grant low for its one cycle and arbitrates at its end,
                // so consecutive grants are separated by exactly one zero cycle.
                IDLE, RELEASE: begin
                    if (win_found) begin
                        grant        <= NUM_REQ'(1) << win_id;
                        grant_id     <= win_id;
                        hold_cnt_reg <= '0;
                        state_reg    <= GRANT;
                    end else begin
                        grant     <= '0;
                        state_reg <= IDLE;
                    end
                end
                GRANT: begin
                    if (!req[grant_id]) begin
                        grant      <= '0;
                        rr_ptr_reg <= ptr_next;
                        state_reg  <= RELEASE;
                    end else if (MAX_HOLD != 0 && hold_cnt_reg == HOLD_LAST) begin
                        grant           <= '0;
                        hold_timeout    <= 1'b1;
                        timeout_id      <= grant_id;
                        rr_ptr_reg      <= ptr_next;
                        revoke_mask_reg <= (revoke_mask_reg & req) | (NUM_REQ'(1) << grant_id);
                        state_reg       <= RELEASE;
                    end else if (hold_cnt_reg != HOLD_SAT) begin
                        hold_cnt_reg <= hold_cnt_reg + CW'(1);
                    end
                end
                default: begin
                    grant     <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_ep_arbiter.sv
// Bench for usb_ep_arbiter (4 requesters, 8-cycle watchdog): directed scenarios
// plus random request traffic compared against an ownership-level reference model.
module tb_usb_ep_arbiter;

    localparam int NR = 4;
    localparam int MH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       hold_timeout;
    logic [1:0] timeout_id;

    int total = 0;
    int bad = 0;

    // Reference model: who owns the port, for how many cycles, and who is barred
    int         m_owner;
    int         m_held;
    int         m_ptr;
    logic [3:0] m_rev;
    int         m_gid;
    int         m_tid;
    logic       m_to;

    usb_ep_arbiter #(.NUM_REQ(NR), .MAX_HOLD(MH)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .grant(grant),
        .grant_valid(grant_valid),
        .grant_id(grant_id),
        .hold_timeout(hold_timeout),
        .timeout_id(timeout_id)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic [3:0] r, input logic rst);
        if (rst) begin
            m_owner = -1; m_held = 0; m_ptr = 0; m_rev = '0;
            m_gid = 0; m_tid = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            m_rev = m_rev & r;
            if (m_owner >= 0) begin
                if (!r[m_owner]) begin
                    m_ptr = (m_owner + 1) % NR;
                    m_owner = -1;
                end else if (m_held == MH) begin
                    m_to = 1'b1;
                    m_tid = m_owner;
                    m_rev[m_owner] = 1'b1;
                    m_ptr = (m_owner + 1) % NR;
                    m_owner = -1;
                end else begin
                    m_held++;
                end
            end else begin
                for (int k = 0; k < NR; k++) begin
                    int i;
                    i = (m_ptr + k) % NR;
                    if (m_owner < 0 && r[i] && !m_rev[i]) begin
                        m_owner = i;
                        m_held = 1;
                        m_gid = i;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic rst);
        req = r;
        reset = rst;
        @(posedge clk);
        model_edge(r, rst);
        #1;
    endtask

    task automatic test_reset;
        step(4'hF, 1'b1);
        step(4'hF, 1'b1);
        total++;
        if ({grant, grant_valid, grant_id, hold_timeout, timeout_id} !== 10'd0) begin
            bad++;
            $display("FAIL reset_outputs got grant=%b gv=%b gid=%0d to=%b tid=%0d need all zero",
                     grant, grant_valid, grant_id, hold_timeout, timeout_id);
        end
        step(4'h0, 1'b0);
        total++;
        if (grant !== 4'b0) begin
            bad++;
            $display("FAIL reset_idle got grant=%b need 0000", grant);
        end
    endtask

    task automatic test_single;
        step(4'h0, 1'b1);
        step(4'h0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            step(4'b0100, 1'b0);
            total++;
            if (grant !== 4'b0100 || grant_id !== 2'd2 || grant_valid !== 1'b1) begin
                bad++;
                $display("FAIL single_grant cyc=%0d got grant=%b gid=%0d gv=%b need 0100/2/1",
                         c, grant, grant_id, grant_valid);
            end
        end
        step(4'h0, 1'b0);
        total++;
        if (grant !== 4'b0 || grant_id !== 2'd2 || grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_release got grant=%b gid=%0d gv=%b need 0000/2/0",
                     grant, grant_id, grant_valid);
        end
    endtask

    task automatic test_all_four;
        logic [3:0] r;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int seen, zeros, held_obs;
        r = 4'hF; seen = 0; zeros = 0; held_obs = 0;
        step(4'h0, 1'b1);
        for (int c = 0; c < 60 && seen < 5; c++) begin
            step(r, 1'b0);
            r = 4'hF;
            if (grant !== 4'b0) begin
                if (held_obs == 0) begin
                    total++;
                    if (int'(grant_id) != exp_order[seen]) begin
                        bad++;
                        $display("FAIL all4_order idx=%0d got %0d need %0d", seen, grant_id, exp_order[seen]);
                    end
                    if (seen > 0) begin
                        total++;
                        if (zeros != 1) begin
                            bad++;
                            $display("FAIL all4_gap idx=%0d got %0d zero cycles need 1", seen, zeros);
                        end
                    end
                    seen++;
                end
                held_obs++;
                zeros = 0;
                if (held_obs == 3) r = r & ~grant;
            end else begin
                held_obs = 0;
                zeros++;
            end
        end
        total++;
        if (seen != 5) begin
            bad++;
            $display("FAIL all4_budget got %0d grants need 5", seen);
        end
    endtask

    task automatic test_fairness;
        logic [3:0] r;
        logic [3:0] prev;
        int seen;
        int exp_id;
        r = 4'b1010; prev = '0; seen = 0; exp_id = 1;
        step(4'h0, 1'b1);
        for (int c = 0; c < 60 && seen < 6; c++) begin
            step(r, 1'b0);
            r = 4'b1010;
            if (grant !== 4'b0 && prev === 4'b0) begin
                total++;
                if (int'(grant_id) != exp_id) begin
                    bad++;
                    $display("FAIL fair_order idx=%0d got %0d need %0d", seen, grant_id, exp_id);
                end
                exp_id = (exp_id == 1) ? 3 : 1;
                seen++;
                r = r & ~grant;
            end
            prev = grant;
        end
        total++;
        if (seen != 6) begin
            bad++;
            $display("FAIL fair_budget got %0d grants need 6", seen);
        end
    endtask

    task automatic test_watchdog;
        logic [3:0] rs[20] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
                               4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0001,
                               4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001};
        logic [3:0] gs[20] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                               4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
                               4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
        step(4'h0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            step(rs[c], 1'b0);
            total++;
            if (grant !== gs[c] || hold_timeout !== (c == 8)) begin
                bad++;
                $display("FAIL watchdog cyc=%0d got grant=%b to=%b need grant=%b to=%b",
                         c, grant, hold_timeout, gs[c], (c == 8));
            end
            if (c == 8) begin
                total++;
                if (timeout_id !== 2'd0) begin
                    bad++;
                    $display("FAIL watchdog_tid got %0d need 0", timeout_id);
                end
            end
        end
    endtask

    task automatic test_tie;
        step(4'h0, 1'b1);
        for (int c = 0; c < 8; c++) step(4'b0001, 1'b0);
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL tie_held got grant=%b need 0001", grant);
        end
        step(4'b0000, 1'b0);
        total++;
        if (grant !== 4'b0 || hold_timeout !== 1'b0) begin
            bad++;
            $display("FAIL tie_release got grant=%b to=%b need 0000/0", grant, hold_timeout);
        end
        step(4'b0001, 1'b0);
        total++;
        if (grant !== 4'b0001 || hold_timeout !== 1'b0) begin
            bad++;
            $display("FAIL tie_regrant got grant=%b to=%b need 0001/0", grant, hold_timeout);
        end
        step(4'b0000, 1'b0);
    endtask

    task automatic test_reset_mid;
        step(4'h0, 1'b1);
        for (int c = 0; c < 4; c++) step(4'b1000, 1'b0);
        total++;
        if (grant !== 4'b1000 || grant_id !== 2'd3) begin
            bad++;
            $display("FAIL rstmid_grant got grant=%b gid=%0d need 1000/3", grant, grant_id);
        end
        step(4'b1000, 1'b1);
        total++;
        if ({grant, grant_valid, grant_id, hold_timeout, timeout_id} !== 10'd0) begin
            bad++;
            $display("FAIL rstmid_clear got grant=%b gv=%b gid=%0d to=%b tid=%0d need all zero",
                     grant, grant_valid, grant_id, hold_timeout, timeout_id);
        end
        step(4'hF, 1'b0);
        total++;
        if (grant !== 4'b0001 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL rstmid_first got grant=%b gid=%0d need 0001/0", grant, grant_id);
        end
    endtask

    task automatic test_random;
        logic [3:0] r;
        logic [3:0] eg;
        logic       rst;
        int         timeouts;
        r = '0; timeouts = 0;
        step(4'h0, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++)
                if ($urandom_range(0, 11) == 0) r[i] = ~r[i];
            rst = ($urandom_range(0, 499) == 0);
            step(r, rst);
            eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            if (m_to) timeouts++;
            total++;
            if (grant !== eg || grant_valid !== (eg != 0) || int'(grant_id) != m_gid ||
                hold_timeout !== m_to || int'(timeout_id) != m_tid) begin
                bad++;
                $display("FAIL random cyc=%0d req=%b got g=%b gv=%b gid=%0d to=%b tid=%0d need g=%b gv=%b gid=%0d to=%b tid=%0d",
                         c, r, grant, grant_valid, grant_id, hold_timeout, timeout_id,
                         eg, (eg != 0), m_gid, m_to, m_tid);
            end
        end
        $display("random: 3000 cycles, %0d watchdog revocations", timeouts);
    endtask

    initial begin
        model_edge(4'h0, 1'b1);
        test_reset;
        test_single;
        test_all_four;
        test_fairness;
        test_watchdog;
        test_tie;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
